// File: rtl/mem_bus_pkg.sv
// Shared command/state encodings for the memory/IO bus controller.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    MCMD_NONE  = 2'b00,
    MCMD_READ  = 2'b01,
    MCMD_WRITE = 2'b10,
    MCMD_RSVD  = 2'b11
  } mcmd_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_RD_WAIT = 2'b01,
    S_WR      = 2'b10,
    S_DONE    = 2'b11
  } state_e;

  localparam int RAM_LAT_MAX = 4;

  // Transaction either faults (reserved cmd) or targets an address outside the two IO registers.
  function automatic logic is_bad(input mcmd_e cmd, input logic io, input logic hit_led,
                                  input logic hit_sw);
    return (cmd == MCMD_RSVD) || (io && !hit_led && !hit_sw);
  endfunction

endpackage

// File: rtl/mem_bus_ctrl_sync2.sv
// Two-flop synchroniser for asynchronous multi-bit inputs (static switch levels).
module sync2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Handshaked memory/IO bus controller: cpu port to RAM plus LED/switch registers.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int            AW       = 9,
  parameter int            DW       = 16,
  parameter int            RAM_LAT  = 1,
  parameter logic [AW-1:0] LED_ADDR = 9'h100,
  parameter logic [AW-1:0] SW_ADDR  = 9'h140
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    mem_cmd,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] write_data,
  output logic [DW-1:0] read_data,
  output logic          mem_ready,
  output logic          err,
  output logic [AW-1:0] ram_addr,
  output logic          ram_write,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  input  logic [DW-1:0] sw_in,
  output logic [DW-1:0] led_out
);

  localparam int CW = $clog2(RAM_LAT + 1);

  mcmd_e         cmd_in;
  state_e        state, state_nxt;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;
  mcmd_e         req_cmd;
  logic [CW-1:0] cnt;
  logic [DW-1:0] sw_sync;
  logic          accept, io_sel, hit_led, hit_sw, bad, rd_last;

  assign cmd_in  = mcmd_e'(mem_cmd);
  assign accept  = (state == S_IDLE) && (cmd_in != MCMD_NONE);
  assign io_sel  = mem_addr[AW-1];
  assign hit_led = (mem_addr == LED_ADDR);
  assign hit_sw  = (mem_addr == SW_ADDR);
  assign bad     = is_bad(cmd_in, io_sel, hit_led, hit_sw);
  assign rd_last = (cnt == CW'(RAM_LAT - 1));

  sync2 #(.W(DW)) u_sw_sync (
    .clk  (clk),
    .rst_n(reset),
    .d    (sw_in),
    .q    (sw_sync)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          if (bad || io_sel)           state_nxt = S_DONE;
          else if (cmd_in == MCMD_READ) state_nxt = S_RD_WAIT;
          else                         state_nxt = S_WR;
        end
      end
      S_RD_WAIT: if (rd_last) state_nxt = S_DONE;
      S_WR:      state_nxt = S_DONE;
      S_DONE:    state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decode straight from state so reset kills them asynchronously.
  always_comb begin
    mem_ready = 1'b0;
    ram_write = 1'b0;
    unique case (state)
      S_WR:    ram_write = (req_cmd == MCMD_WRITE);
      S_DONE:  mem_ready = 1'b1;
      default: ;
    endcase
  end

  // IO accesses and errors resolve on the accept edge; RAM reads capture on the last wait cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_addr  <= '0;
      req_data  <= '0;
      req_cmd   <= MCMD_NONE;
      cnt       <= '0;
      read_data <= '0;
      led_out   <= '0;
      err       <= 1'b0;
    end else begin
      if (accept) begin
        req_addr <= mem_addr;
        req_data <= write_data;
        req_cmd  <= cmd_in;
        cnt      <= '0;
        if (bad) begin
          err <= 1'b1;
        end else if (io_sel) begin
          if (cmd_in == MCMD_READ) read_data <= hit_led ? led_out : sw_sync;
          else if (hit_led)        led_out   <= write_data;
        end
      end
      if (state == S_RD_WAIT) begin
        cnt <= cnt + CW'(1);
        if (rd_last) read_data <= ram_dout;
      end
    end
  end

  assign ram_addr = req_addr;
  assign ram_din  = req_data;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench: three controllers (RAM_LAT 1, 2, 4) each with its own RAM model.
module tb_mem_bus_ctrl;

  localparam int NI = 3;
  localparam logic [1:0] C_NONE = 2'b00, C_RD = 2'b01, C_WR = 2'b10, C_RSVD = 2'b11;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  cmd   [NI];
  logic [8:0]  addr;
  logic [15:0] wdata, sw;
  logic [15:0] rdata [NI];
  logic        ready [NI];
  logic        err_o [NI];
  logic        ramw  [NI];
  logic [8:0]  raddr [NI];
  logic [15:0] rdin  [NI];
  logic [15:0] rdout [NI];
  logic [15:0] led   [NI];
  int          wrcnt [NI];
  int          nvec = 0, nerr = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    logic [15:0] mem  [256];
    logic [15:0] pipe [4];

    mem_bus_ctrl #(.AW(9), .DW(16), .RAM_LAT(L), .LED_ADDR(9'h100), .SW_ADDR(9'h140)) dut (
      .clk       (clk),
      .reset     (rst_n),
      .mem_cmd   (cmd[g]),
      .mem_addr  (addr),
      .write_data(wdata),
      .read_data (rdata[g]),
      .mem_ready (ready[g]),
      .err       (err_o[g]),
      .ram_addr  (raddr[g]),
      .ram_write (ramw[g]),
      .ram_din   (rdin[g]),
      .ram_dout  (rdout[g]),
      .sw_in     (sw),
      .led_out   (led[g])
    );

    // Data for an address held from cycle 1 is valid by cycle L.
    always @(posedge clk) begin
      if (ramw[g]) mem[raddr[g][7:0]] <= rdin[g];
      pipe[0] <= mem[raddr[g][7:0]];
      for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    if (L == 1) begin : g_l1
      assign rdout[g] = mem[raddr[g][7:0]];
    end else begin : g_ln
      assign rdout[g] = pipe[L-2];
    end
  end

  initial for (int k = 0; k < NI; k++) wrcnt[k] = 0;
  always @(negedge clk) for (int k = 0; k < NI; k++) if (ramw[k] === 1'b1) wrcnt[k]++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command, hold until mem_ready, then drop it and wait one cycle back into IDLE.
  task automatic txn(input int k, input logic [1:0] c, input logic [8:0] a, input logic [15:0] d,
                     output int lat, output int wr_at);
    @(negedge clk);
    cmd[k] = c; addr = a; wdata = d;
    lat = 0; wr_at = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ramw[k] && wr_at == 0) wr_at = i;
      if (ready[k]) begin lat = i; break; end
    end
    cmd[k] = C_NONE;
    chk("txn_complete", {31'b0, lat != 0}, 32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat, wr_at, w0, prev, pulses;
    int exp_lat [NI];
    exp_lat = '{1, 2, 4};
    rst_n = 1'b0; addr = '0; wdata = '0; sw = '0;
    for (int k = 0; k < NI; k++) cmd[k] = C_NONE;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", rdata[1], 0);
    chk("rst_ready", ready[1], 0);
    chk("rst_err",   err_o[1], 0);
    chk("rst_led",   led[1],   0);
    chk("rst_ramw",  ramw[1],  0);
    chk("rst_raddr", raddr[1], 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // RAM write/read at each latency
    for (int k = 0; k < NI; k++) begin
      w0 = wrcnt[k];
      txn(k, C_WR, 9'h005, 16'hABCD, lat, wr_at);
      chk($sformatf("ramwr_at_%0d", k),  wr_at, 1);
      chk($sformatf("ramwr_lat_%0d", k), lat, 2);
      chk($sformatf("ramwr_cnt_%0d", k), wrcnt[k] - w0, 1);
      txn(k, C_RD, 9'h005, 16'h0000, lat, wr_at);
      chk($sformatf("ramrd_lat_%0d", k),  lat, exp_lat[k] + 1);
      chk($sformatf("ramrd_data_%0d", k), rdata[k], 16'hABCD);
    end

    // LED register
    w0 = wrcnt[1];
    txn(1, C_WR, 9'h100, 16'h00F0, lat, wr_at);
    chk("ledwr_lat", lat, 1);
    chk("ledwr_val", led[1], 16'h00F0);
    txn(1, C_RD, 9'h100, 16'h0000, lat, wr_at);
    chk("ledrd_lat",  lat, 1);
    chk("ledrd_data", rdata[1], 16'h00F0);
    chk("led_noramw", wrcnt[1] - w0, 0);

    // Switch input through the synchroniser
    sw = 16'h1234;
    repeat (3) @(posedge clk);
    txn(1, C_RD, 9'h140, 16'h0000, lat, wr_at);
    chk("swrd_lat",  lat, 1);
    chk("swrd_data", rdata[1], 16'h1234);
    txn(1, C_WR, 9'h140, 16'hFFFF, lat, wr_at);
    chk("swwr_lat",   lat, 1);
    chk("swwr_err",   err_o[1], 0);
    chk("swwr_led",   led[1], 16'h00F0);
    chk("swwr_noram", wrcnt[1] - w0, 0);

    // Unmapped IO then reserved command
    txn(1, C_RD, 9'h1FF, 16'h0000, lat, wr_at);
    chk("unmap_lat",   lat, 1);
    chk("unmap_err",   err_o[1], 1);
    chk("unmap_rdata", rdata[1], 16'h1234);
    txn(1, C_RSVD, 9'h005, 16'h5555, lat, wr_at);
    chk("rsvd_lat",   lat, 1);
    chk("rsvd_err",   err_o[1], 1);
    chk("rsvd_rdata", rdata[1], 16'h1234);
    chk("rsvd_noram", wrcnt[1] - w0, 0);
    txn(1, C_RD, 9'h100, 16'h0000, lat, wr_at);
    chk("sticky_err",   err_o[1], 1);
    chk("sticky_rdata", rdata[1], 16'h00F0);

    // Held read: ready every RAM_LAT+2 = 4 cycles
    @(negedge clk);
    cmd[1] = C_RD; addr = 9'h005;
    prev = -1; pulses = 0;
    for (int i = 1; i <= 24; i++) begin
      @(posedge clk); #1;
      if (ready[1]) begin
        if (prev >= 0) chk("hold_gap", i - prev, 4);
        prev = i;
        pulses++;
      end
      if (i == 24) cmd[1] = C_NONE;
    end
    chk("hold_pulses", pulses, 6);
    chk("hold_data", rdata[1], 16'hABCD);
    repeat (2) @(posedge clk);

    // Reset mid-WR (lat 2) and mid-RD_WAIT (lat 4)
    w0 = wrcnt[1];
    @(negedge clk);
    cmd[1] = C_WR; cmd[2] = C_RD; addr = 9'h005; wdata = 16'h1111;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_ramw",   ramw[1], 0);
    chk("mrst_ready1", ready[1], 0);
    chk("mrst_err",    err_o[1], 0);
    chk("mrst_rdata",  rdata[1], 0);
    chk("mrst_led",    led[1], 0);
    chk("mrst_raddr",  raddr[1], 0);
    chk("mrst_ready2", ready[2], 0);
    cmd[1] = C_NONE; cmd[2] = C_NONE;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mrst_nowrite", wrcnt[1] - w0, 0);
    txn(1, C_RD, 9'h005, 16'h0000, lat, wr_at);
    chk("post_lat1",  lat, 3);
    chk("post_data1", rdata[1], 16'hABCD);
    txn(2, C_RD, 9'h005, 16'h0000, lat, wr_at);
    chk("post_lat2",  lat, 5);
    chk("post_data2", rdata[2], 16'hABCD);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
